run_ctrl: RTL and testbench

Run controller between the host request/acknowledge handshake and the core's program counter. It sits directly upstream of the fetch/execute datapath inside prog. A req pulse starts a run: the PC is enabled from its current position until the decoder flags a halt instruction, then ack is raised. A watchdog ends a run that never halts, and the block keeps run and cycle statistics for the bench.

---
 rtl/run_ctrl.sv | 78 +++++++
 tb/tb_run_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/run_ctrl.sv
// Run controller: turns a host req rising edge into a PC-enable run that ends on halt or watchdog,
// then holds ack/timeout and keeps run and cycle statistics.
module run_ctrl #(
  parameter int unsigned MAX_CYCLES = 1024,
  parameter int unsigned CNT_W      = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic             halt,
  output logic             pc_en,
  output logic             ack,
  output logic             busy,
  output logic             timeout,
  output logic [7:0]       run_count,
  output logic [CNT_W-1:0] cycle_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CYCLE = CNT_W'(MAX_CYCLES - 1);

  state_t state;
  logic   req_q;
  logic   req_rise;

  assign req_rise = req & ~req_q;

  // busy is a register mirroring state==RUN; pc_en is the same registered signal
  assign pc_en = busy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      req_q       <= 1'b0;
      busy        <= 1'b0;
      ack         <= 1'b0;
      timeout     <= 1'b0;
      run_count   <= 8'd0;
      cycle_count <= '0;
    end else begin
      req_q <= req;
      case (state)
        IDLE, DONE: begin
          if (req_rise) begin
            state       <= RUN;
            busy        <= 1'b1;
            ack         <= 1'b0;
            timeout     <= 1'b0;
            cycle_count <= '0;
          end
        end
        RUN: begin
          cycle_count <= cycle_count + CNT_W'(1);
          // halt takes priority over the watchdog in the same cycle
          if (halt || (cycle_count == LAST_CYCLE)) begin
            state   <= DONE;
            busy    <= 1'b0;
            ack     <= 1'b1;
            timeout <= ~halt;
            if (run_count != 8'hFF) begin
              run_count <= run_count + 8'd1;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_run_ctrl.sv
// Self-checking bench for run_ctrl: directed vector table, reset-mid-run sequence,
// and randomized runs checked against a per-run transaction model.
module tb_run_ctrl;

  localparam int unsigned MAXC = 16;
  localparam int unsigned CW   = 5;

  logic          clk;
  logic          reset;
  logic          req;
  logic          halt;
  logic          pc_en;
  logic          ack;
  logic          busy;
  logic          timeout;
  logic [7:0]    run_count;
  logic [CW-1:0] cycle_count;

  int checks;
  int failures;
  int rc_model;

  run_ctrl #(.MAX_CYCLES(MAXC), .CNT_W(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .halt       (halt),
    .pc_en      (pc_en),
    .ack        (ack),
    .busy       (busy),
    .timeout    (timeout),
    .run_count  (run_count),
    .cycle_count(cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int   halt_at;    // RUN cycle on which halt is shown, 0 = never
    int   req_len;    // cycles req is held high
    int   inject_at;  // RUN cycle with an extra req rising edge, 0 = none
    int   exp_cycles;
    logic exp_timeout;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive one run; halt model asserts halt during the halt_at-th RUN cycle.
  task automatic do_run(input int halt_at, input int req_len, input int inject_at,
                        output int pc_cycles, output int ack_rises, output int first_pc,
                        output int ack_at_start, output int ack_dropped, output int done_ok);
    logic prev_ack;
    pc_cycles = 0; ack_rises = 0; first_pc = -1; ack_at_start = 0;
    ack_dropped = 0; done_ok = 0; prev_ack = 1'b0;
    req = 1'b1;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (n == 0) ack_at_start = int'(ack);
      if (pc_en) begin
        pc_cycles++;
        if (first_pc < 0) first_pc = n;
      end
      halt = pc_en && (pc_cycles == halt_at);
      req  = ((n + 1) < req_len) || (inject_at != 0 && pc_en && pc_cycles == inject_at);
      if (ack && !prev_ack) ack_rises++;
      if (!ack && prev_ack) ack_dropped++;
      prev_ack = ack;
      if (ack && !pc_en && n >= req_len) begin
        done_ok = 1;
        break;
      end
    end
    halt = 1'b0;
    req  = 1'b0;
  endtask

  task automatic run_and_check(input string tag, input int halt_at, input int req_len,
                               input int inject_at, input int exp_cycles, input logic exp_to);
    int pc_cycles, ack_rises, first_pc, ack_at_start, ack_dropped, done_ok;
    do_run(halt_at, req_len, inject_at, pc_cycles, ack_rises, first_pc,
           ack_at_start, ack_dropped, done_ok);
    if (rc_model < 255) rc_model++;
    check({tag, " completed"}, done_ok, 1);
    check({tag, " ack_cleared_at_start"}, ack_at_start, 0);
    check({tag, " start_latency"}, first_pc, 0);
    check({tag, " pc_en_cycles"}, pc_cycles, exp_cycles);
    check({tag, " ack_rises"}, ack_rises, 1);
    check({tag, " ack_dropped"}, ack_dropped, 0);
    check({tag, " cycle_count"}, int'(cycle_count), exp_cycles);
    check({tag, " timeout"}, int'(timeout), int'(exp_to));
    check({tag, " run_count"}, int'(run_count), rc_model);
    check({tag, " busy"}, int'(busy), 0);
  endtask

  initial begin
    int h, rl, ec, k;
    logic et;
    checks = 0; failures = 0; rc_model = 0;

    vecs[0] = '{halt_at: 3, req_len: 1,  inject_at: 0, exp_cycles: 3,  exp_timeout: 1'b0};
    vecs[1] = '{halt_at: 1, req_len: 20, inject_at: 0, exp_cycles: 1,  exp_timeout: 1'b0};
    vecs[2] = '{halt_at: 0, req_len: 1,  inject_at: 0, exp_cycles: 16, exp_timeout: 1'b1};
    vecs[3] = '{halt_at: 2, req_len: 1,  inject_at: 0, exp_cycles: 2,  exp_timeout: 1'b0};
    vecs[4] = '{halt_at: 5, req_len: 1,  inject_at: 2, exp_cycles: 5,  exp_timeout: 1'b0};

    reset = 1'b1; req = 1'b0; halt = 1'b0;
    #1;
    check("reset pc_en", int'(pc_en), 0);
    check("reset ack", int'(ack), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("idle ack", int'(ack), 0);
    check("idle pc_en", int'(pc_en), 0);
    check("idle busy", int'(busy), 0);
    check("idle timeout", int'(timeout), 0);
    check("idle run_count", int'(run_count), 0);
    check("idle cycle_count", int'(cycle_count), 0);

    for (int i = 0; i < 5; i++) begin
      run_and_check($sformatf("vec%0d", i), vecs[i].halt_at, vecs[i].req_len,
                    vecs[i].inject_at, vecs[i].exp_cycles, vecs[i].exp_timeout);
      repeat (2) @(negedge clk);
    end

    // Reset asserted during RUN cycle 4 must drop everything immediately.
    k = 0;
    req = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      req = 1'b0;
      if (pc_en) k++;
      if (k == 4) break;
    end
    check("midrun reached_cycle4", k, 4);
    #2 reset = 1'b1;
    #1;
    check("midrun pc_en", int'(pc_en), 0);
    check("midrun busy", int'(busy), 0);
    check("midrun ack", int'(ack), 0);
    check("midrun run_count", int'(run_count), 0);
    @(negedge clk);
    reset = 1'b0;
    rc_model = 0;
    @(negedge clk);
    run_and_check("post_reset", 3, 1, 0, 3, 1'b0);
    repeat (2) @(negedge clk);

    // Randomized runs against the per-run model.
    for (int i = 0; i < 25; i++) begin
      h  = int'($urandom_range(0, 20));
      rl = int'($urandom_range(1, 4));
      if (h >= 1 && h <= int'(MAXC)) begin
        ec = h; et = 1'b0;
      end else begin
        ec = int'(MAXC); et = 1'b1;
      end
      run_and_check($sformatf("rand%0d", i), h, rl, 0, ec, et);
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
